// File: rtl/collatz_caller_if.sv
// Bundle between collatz_caller and its environment: command in, kernel call/return, result stream out.
// cmd and res are valid/ready: a beat moves on a posedge where valid&&ready; valid never drops and the payload never changes until that beat moves.
interface collatz_caller_if #(
  parameter int W = 32
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_lo;
  logic [W-1:0] cmd_hi;
  logic         kern_rst_n;
  logic         kern_start;
  logic [W-1:0] kern_n;
  logic         kern_finish;
  logic [W-1:0] kern_ret;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_n;
  logic [W-1:0] res_ret;
  logic         res_timeout;
  logic         done;
  logic [W-1:0] max_ret;
  logic [W-1:0] max_n;
  logic         any_timeout;
  logic [2:0]   state_dbg;

  modport master (
    input  cmd_valid, cmd_lo, cmd_hi, kern_finish, kern_ret, res_ready,
    output cmd_ready, kern_rst_n, kern_start, kern_n, res_valid, res_n, res_ret,
           res_timeout, done, max_ret, max_n, any_timeout, state_dbg
  );

  modport slave (
    output cmd_valid, cmd_lo, cmd_hi, kern_finish, kern_ret, res_ready,
    input  cmd_ready, kern_rst_n, kern_start, kern_n, res_valid, res_n, res_ret,
           res_timeout, done, max_ret, max_n, any_timeout, state_dbg
  );
endinterface

// File: rtl/collatz_caller.sv
// Calls a single-argument HLS kernel once per argument in [lo, hi], resetting it before each call,
// streams one result per call and tracks the largest non-timeout return of the command.
module collatz_caller #(
  parameter int W          = 32,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic             clk,
  input  logic             rst,
  collatz_caller_if.master bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    KRST = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int CMAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [W-1:0]  hi_q, hi_d, cur_d;
  logic [W-1:0]  res_n_d, res_ret_d, max_ret_d, max_n_d;
  logic          res_timeout_d, any_timeout_d;
  logic          have_max, have_max_d;
  logic          cmd_acc, res_acc, last_call, krst_end, wait_end;

  // kern_n doubles as the current-argument register.
  assign cmd_acc   = (state == IDLE) && bus.cmd_valid && bus.cmd_ready;
  assign res_acc   = (state == EMIT) && bus.res_valid && bus.res_ready;
  assign last_call = (bus.kern_n == hi_q);
  assign krst_end  = (cnt == CW'(RST_CYCLES - 1));
  assign wait_end  = (cnt == CW'(TIMEOUT - 1));
  assign bus.state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      hi_q            <= '0;
      have_max        <= 1'b0;
      bus.cmd_ready   <= 1'b0;
      bus.kern_rst_n  <= 1'b0;
      bus.kern_start  <= 1'b0;
      bus.kern_n      <= '0;
      bus.res_valid   <= 1'b0;
      bus.res_n       <= '0;
      bus.res_ret     <= '0;
      bus.res_timeout <= 1'b0;
      bus.done        <= 1'b0;
      bus.max_ret     <= '0;
      bus.max_n       <= '0;
      bus.any_timeout <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      hi_q            <= hi_d;
      have_max        <= have_max_d;
      bus.cmd_ready   <= (state_d == IDLE);
      bus.kern_rst_n  <= (state_d != KRST);
      bus.kern_start  <= (state_d == WAIT);
      bus.kern_n      <= cur_d;
      bus.res_valid   <= (state_d == EMIT);
      bus.res_n       <= res_n_d;
      bus.res_ret     <= res_ret_d;
      bus.res_timeout <= res_timeout_d;
      bus.done        <= (state_d == DONE);
      bus.max_ret     <= max_ret_d;
      bus.max_n       <= max_n_d;
      bus.any_timeout <= any_timeout_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (cmd_acc) state_d = (bus.cmd_lo > bus.cmd_hi) ? DONE : KRST;
      KRST: if (krst_end) state_d = WAIT;
      WAIT: if (bus.kern_finish || wait_end) state_d = EMIT;
      EMIT: if (res_acc) state_d = last_call ? DONE : KRST;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = (state_d != state) ? '0 : cnt + 1'b1;
    hi_d          = hi_q;
    cur_d         = bus.kern_n;
    have_max_d    = have_max;
    res_n_d       = bus.res_n;
    res_ret_d     = bus.res_ret;
    res_timeout_d = bus.res_timeout;
    max_ret_d     = bus.max_ret;
    max_n_d       = bus.max_n;
    any_timeout_d = bus.any_timeout;
    case (state)
      IDLE: if (cmd_acc) begin
        hi_d          = bus.cmd_hi;
        cur_d         = bus.cmd_lo;
        have_max_d    = 1'b0;
        max_ret_d     = '0;
        max_n_d       = '0;
        any_timeout_d = 1'b0;
      end
      WAIT: begin
        // finish is checked first so it wins on the timeout boundary
        if (bus.kern_finish) begin
          res_n_d       = bus.kern_n;
          res_ret_d     = bus.kern_ret;
          res_timeout_d = 1'b0;
        end else if (wait_end) begin
          res_n_d       = bus.kern_n;
          res_ret_d     = '1;
          res_timeout_d = 1'b1;
          any_timeout_d = 1'b1;
        end
      end
      EMIT: if (res_acc) begin
        if (!bus.res_timeout && (!have_max || bus.res_ret > bus.max_ret)) begin
          max_ret_d  = bus.res_ret;
          max_n_d    = bus.res_n;
          have_max_d = 1'b1;
        end
        // compare before increment: hi = all-ones never wraps
        if (!last_call) cur_d = bus.kern_n + 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_collatz_caller.sv
// Bench for collatz_caller: a Collatz step-count kernel stub, random and directed commands,
// and a scoreboard fed from an arithmetic reference model.
module tb_collatz_caller;
  localparam int W          = 32;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  collatz_caller_if #(.W(W)) bus ();

  collatz_caller #(.W(W), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string info);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, info, $time);
  endtask

  // ---------------- reference model ----------------
  int           kern_mode = 0;   // 0: Collatz step count, 1: constant 5
  logic         hang_en   = 1'b0;
  logic [W-1:0] hang_n    = '0;

  function automatic logic [W-1:0] collatz_steps(input logic [W-1:0] n0);
    longint unsigned v;
    int s;
    v = n0;
    s = 0;
    while (v > 1 && s < 100000) begin
      v = (v % 2 == 1) ? 3 * v + 1 : v / 2;
      s++;
    end
    return W'(s);
  endfunction

  function automatic logic [W-1:0] ref_ret(input logic [W-1:0] n);
    return (kern_mode == 1) ? W'(5) : collatz_steps(n);
  endfunction

  // ---------------- kernel stub ----------------
  logic         k_busy = 1'b0;
  int           k_cnt  = 0;
  logic [W-1:0] k_val  = '0;
  always @(posedge clk) begin
    if (!bus.kern_rst_n) begin
      bus.kern_finish <= 1'b0;
      bus.kern_ret    <= '0;
      k_busy          <= 1'b0;
    end else if (k_busy) begin
      if (k_cnt == 0) begin
        bus.kern_finish <= 1'b1;
        bus.kern_ret    <= k_val;
        k_busy          <= 1'b0;
      end else begin
        k_cnt <= k_cnt - 1;
      end
    end else if (bus.kern_start && !bus.kern_finish && !(hang_en && bus.kern_n == hang_n)) begin
      k_busy <= 1'b1;
      k_cnt  <= $urandom_range(0, 8);
      k_val  <= ref_ret(bus.kern_n);
    end
  end

  // ---------------- result-side ready driver ----------------
  int ready_mode = 0;   // 0: always ready, 1: random, 2: held low
  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.res_ready = 1'b1;
        1:       bus.res_ready = 1'($urandom_range(0, 1));
        default: bus.res_ready = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  logic [2*W:0] exp_q[$];        // {timeout, n, ret}
  logic [2*W:0] exp_done_q[$];   // {any_timeout, max_n, max_ret}
  int   beat_cnt = 0, done_cnt = 0;
  int   last_acc_edge = 0, start_edge = 0;
  int   low_run = 0, last_low_run = 0;
  logic prev_start = 1'b0, prev_valid = 1'b0, prev_done = 1'b0;

  initial begin
    logic [2*W:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_start = 1'b0;
        prev_valid = 1'b0;
        prev_done  = 1'b0;
        low_run    = 0;
        continue;
      end
      if (!bus.kern_rst_n) low_run++;
      else begin
        if (low_run > 0) last_low_run = low_run;
        low_run = 0;
      end
      if (bus.kern_start && !prev_start) begin
        check("krst_len", last_low_run, RST_CYCLES);
        start_edge = cyc;
      end
      if (bus.res_valid && !prev_valid && bus.res_timeout)
        check("timeout_arrival", cyc - start_edge, TIMEOUT);
      if (bus.res_valid && bus.res_ready) begin
        beat_cnt++;
        last_acc_edge = cyc + 1;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat", $sformatf("actual n=%0h ret=%0h, required no beat", bus.res_n, bus.res_ret));
        end else begin
          e = exp_q.pop_front();
          check("res_n", bus.res_n, e[2*W-1:W]);
          check("res_ret", bus.res_ret, e[W-1:0]);
          check("res_timeout", W'(bus.res_timeout), W'(e[2*W]));
        end
      end
      if (bus.done) begin
        done_cnt++;
        if (prev_done) fail_now("done_width", "actual done high 2+ cycles, required 1");
        check("done_delay", cyc - last_acc_edge + 1, 1);
        check("beats_left_at_done", exp_q.size(), 0);
        if (exp_done_q.size() == 0) begin
          fail_now("unexpected_done", "actual done pulse, required none");
        end else begin
          e = exp_done_q.pop_front();
          check("max_ret", bus.max_ret, e[W-1:0]);
          check("max_n", bus.max_n, e[2*W-1:W]);
          check("any_timeout", W'(bus.any_timeout), W'(e[2*W]));
        end
      end
      prev_start = bus.kern_start;
      prev_valid = bus.res_valid;
      prev_done  = bus.done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset(input int cycles);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    exp_done_q.delete();
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic issue_cmd(input logic [W-1:0] lo, input logic [W-1:0] hi);
    logic [W-1:0] mret, mn, r, nn;
    logic any, have, to;
    int k;
    mret = '0; mn = '0; any = 1'b0; have = 1'b0;
    if (lo <= hi) begin
      for (longint unsigned n = lo; n <= hi; n++) begin
        nn = W'(n);
        to = hang_en && (nn == hang_n);
        r  = to ? '1 : ref_ret(nn);
        exp_q.push_back({to, nn, r});
        if (to) any = 1'b1;
        else if (!have || r > mret) begin
          mret = r; mn = nn; have = 1'b1;
        end
      end
    end
    exp_done_q.push_back({any, mn, mret});
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_lo    = lo;
    bus.cmd_hi    = hi;
    k = 0;
    @(negedge clk);
    while (!bus.cmd_ready && k < 2000) begin
      k++;
      @(negedge clk);
    end
    if (!bus.cmd_ready) begin
      fail_now("cmd_accept_timeout", "actual cmd_ready=0, required 1");
      exp_q.delete();
      exp_done_q.delete();
    end
    last_acc_edge = cyc + 1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == d0) begin
      fail_now("done_timeout", $sformatf("actual no done in %0d cycles, required a done pulse", budget));
      apply_reset(2);
    end
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.res_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!bus.res_valid) fail_now("valid_timeout", "actual res_valid=0, required 1");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int b0, d0, k;
    logic [W-1:0] lo, hi;
    bus.cmd_valid = 1'b0;
    bus.cmd_lo    = '0;
    bus.cmd_hi    = '0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", W'(bus.cmd_ready), 0);
    check("rst_kern_rst_n", W'(bus.kern_rst_n), 0);
    check("rst_kern_start", W'(bus.kern_start), 0);
    check("rst_kern_n", bus.kern_n, 0);
    check("rst_res_valid", W'(bus.res_valid), 0);
    check("rst_res_n", bus.res_n, 0);
    check("rst_res_ret", bus.res_ret, 0);
    check("rst_res_timeout", W'(bus.res_timeout), 0);
    check("rst_done", W'(bus.done), 0);
    check("rst_max_ret", bus.max_ret, 0);
    check("rst_max_n", bus.max_n, 0);
    check("rst_any_timeout", W'(bus.any_timeout), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("cmd_ready_after_rst", W'(bus.cmd_ready), 1);

    // Collatz 1..7, always ready
    ready_mode = 0;
    b0 = beat_cnt; d0 = done_cnt;
    issue_cmd(1, 7);
    wait_done(3000);
    repeat (5) @(negedge clk);
    check("seq_beats", beat_cnt - b0, 7);
    check("seq_dones", done_cnt - d0, 1);

    // backpressure on a single call
    ready_mode = 2;
    b0 = beat_cnt;
    issue_cmd(6, 6);
    wait_valid(500);
    for (int i = 0; i < 10; i++) begin
      check("bp_res_n", bus.res_n, 6);
      check("bp_res_ret", bus.res_ret, 8);
      check("bp_kern_rst_n", W'(bus.kern_rst_n), 1);
      check("bp_kern_start", W'(bus.kern_start), 0);
      @(negedge clk);
    end
    ready_mode = 0;
    wait_done(100);
    check("bp_beats", beat_cnt - b0, 1);

    // timeout on the middle argument
    hang_en = 1'b1;
    hang_n  = 5;
    issue_cmd(4, 6);
    wait_done(3000);
    hang_en = 1'b0;

    // empty range
    b0 = beat_cnt;
    issue_cmd(9, 3);
    wait_done(50);
    check("empty_beats", beat_cnt - b0, 0);

    // upper boundary, constant-return kernel
    kern_mode = 1;
    b0 = beat_cnt; d0 = done_cnt;
    issue_cmd('1, '1);
    wait_done(500);
    repeat (30) @(negedge clk);
    check("top_beats", beat_cnt - b0, 1);
    check("top_dones", done_cnt - d0, 1);
    kern_mode = 0;

    // reset while the kernel is running
    issue_cmd(27, 27);
    k = 0;
    while (!bus.kern_start && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.kern_start) fail_now("wait_entry_timeout", "actual kern_start=0, required 1");
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    exp_done_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_kern_rst_n", W'(bus.kern_rst_n), 0);
    check("midrst_kern_start", W'(bus.kern_start), 0);
    check("midrst_res_valid", W'(bus.res_valid), 0);
    check("midrst_done", W'(bus.done), 0);
    @(negedge clk);
    check("midrst_cmd_ready", W'(bus.cmd_ready), 1);
    issue_cmd(27, 27);
    wait_done(500);

    // randomized commands with random backpressure and occasional hangs
    ready_mode = 1;
    for (int t = 0; t < 12; t++) begin
      lo = W'($urandom_range(1, 60));
      hi = lo + W'($urandom_range(0, 5));
      if ($urandom_range(0, 5) == 0) begin
        hi = lo;
        lo = lo + W'($urandom_range(1, 4));
      end
      hang_en = ($urandom_range(0, 3) == 0);
      hang_n  = lo + W'($urandom_range(0, 5));
      issue_cmd(lo, hi);
      wait_done(5000);
    end
    hang_en    = 1'b0;
    ready_mode = 0;

    repeat (20) @(negedge clk);
    check("final_beats_pending", exp_q.size(), 0);
    check("final_dones_pending", exp_done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
